// File: rtl/audio_sample_packetizer_if.sv
`default_nettype none
// ============================================================================
//  audio_sample_packetizer_if
//  Sample-input / packet-output bundle of the audio sample packetizer.
//  Revision: 1.0
// ============================================================================
interface audio_sample_packetizer_if #(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_WIDTH = 24
);
    logic                             sample_valid;
    logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_word;
    logic                             sample_ready;
    logic                             packet_request;
    logic                             busy;
    logic                             packet_valid;
    logic [23:0]                      header;
    logic [3:0][55:0]                 sub;
    logic                             overflow;

    modport master (
        output sample_valid, sample_word, packet_request,
        input  sample_ready, busy, packet_valid, header, sub, overflow
    );

    modport slave (
        input  sample_valid, sample_word, packet_request,
        output sample_ready, busy, packet_valid, header, sub, overflow
    );
endinterface
`default_nettype wire

// File: rtl/audio_sample_packetizer.sv
`default_nettype none
// ============================================================================
//  audio_sample_packetizer
//  Buffers PCM samples and assembles IEC 60958 audio sample packets on request.
//  Revision: 1.0
// ============================================================================
module audio_sample_packetizer #(
    parameter int         CHANNELS           = 2,
    parameter int         SAMPLE_WIDTH       = 24,
    parameter int         FIFO_DEPTH         = 8,
    parameter logic [3:0] SAMPLING_FREQUENCY = 4'b0000,
    parameter logic [3:0] WORD_LENGTH        = 4'b1011
) (
    input  wire logic                clk_pixel,
    input  wire logic                reset,
    audio_sample_packetizer_if.slave bus
);
    localparam int C_WORD_W = CHANNELS * SAMPLE_WIDTH;
    localparam int C_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int C_PAD    = 24 - SAMPLE_WIDTH;
    localparam int C_PAIRS  = CHANNELS / 2;
    localparam bit C_LAYOUT = (CHANNELS == 8);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        EMIT     = 2'd2
    } state_t;

    // Channel-status bit at a given frame for a 1-based channel number.
    function automatic logic cs_bit(input logic [3:0] chan_num, input logic [7:0] frame);
        logic r;
        r = 1'b0;
        if (frame == 8'd2)                         r = 1'b1;
        else if (frame >= 8'd20 && frame <= 8'd23) r = chan_num[frame[1:0]];
        else if (frame >= 8'd24 && frame <= 8'd27) r = SAMPLING_FREQUENCY[frame[1:0]];
        else if (frame >= 8'd32 && frame <= 8'd35) r = WORD_LENGTH[frame[1:0]];
        return r;
    endfunction

    function automatic logic [55:0] pack_sub(input logic [SAMPLE_WIDTH-1:0] s0,
                                             input logic [SAMPLE_WIDTH-1:0] s1,
                                             input logic [3:0]              num0,
                                             input logic [7:0]              frame);
        logic [23:0] f0, f1;
        logic        c0, c1;
        f0 = 24'(s0) << C_PAD;
        f1 = 24'(s1) << C_PAD;
        c0 = cs_bit(num0, frame);
        c1 = cs_bit(num0 + 4'd1, frame);
        return {^f1 ^ c1, c1, 2'b00, ^f0 ^ c0, c0, 2'b00, f1, f0};
    endfunction

    logic [C_WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [C_ADDR_W-1:0] r_wr_ptr;
    logic [C_ADDR_W-1:0] r_rd_ptr;
    logic [C_ADDR_W:0]   r_count;
    logic                r_overflow;

    state_t              r_state;
    logic [2:0]          r_k;
    logic [1:0]          r_slot;
    logic [7:0]          r_frame;
    logic [3:0][55:0]    r_build;
    logic [3:0]          r_bflag;
    logic [23:0]         r_header;
    logic [3:0][55:0]    r_sub;
    logic                r_packet_valid;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_last;
    logic [2:0]          w_k;
    logic [C_WORD_W-1:0] w_entry;
    logic [55:0]         w_fill [4];
    logic [3:0][55:0]    w_build_next;
    logic [3:0]          w_bflag_next;
    logic [3:0]          w_present;

    assign w_full  = (r_count == (C_ADDR_W+1)'(FIFO_DEPTH));
    assign w_push  = bus.sample_valid && !w_full;
    assign w_pop   = (r_state == ASSEMBLE);
    assign w_entry = r_mem[r_rd_ptr];
    assign w_last  = ({1'b0, r_slot} == (r_k - 3'd1));

    always_comb begin
        w_k = 3'd0;
        if (C_LAYOUT) w_k = (r_count != '0) ? 3'd1 : 3'd0;
        else          w_k = (r_count >= (C_ADDR_W+1)'(4)) ? 3'd4 : 3'(r_count);
    end

    // Subpacket p carries channel pair (2p, 2p+1) of the entry at the FIFO head.
    for (genvar p = 0; p < 4; p++) begin : g_pair
        if (p < C_PAIRS) begin : g_used
            assign w_fill[p] = pack_sub(w_entry[2*p*SAMPLE_WIDTH +: SAMPLE_WIDTH],
                                        w_entry[(2*p+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH],
                                        4'(2*p+1), r_frame);
        end else begin : g_unused
            assign w_fill[p] = '0;
        end
    end

    always_comb begin
        w_build_next = r_build;
        w_bflag_next = r_bflag;
        w_present    = 4'b1111;
        if (C_LAYOUT) begin
            for (int p = 0; p < 4; p++) w_build_next[p] = w_fill[p];
            w_bflag_next = {3'b000, r_frame == 8'd0};
        end else begin
            w_build_next[r_slot] = w_fill[0];
            w_bflag_next[r_slot] = (r_frame == 8'd0);
            w_present            = 4'((5'd1 << r_k) - 5'd1);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.sample_word;
    end

    // A push arriving while full is lost even if a pop frees a slot this cycle.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (bus.sample_valid && w_full) r_overflow <= 1'b1;
            r_count <= r_count + {{C_ADDR_W{1'b0}}, w_push} - {{C_ADDR_W{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_k            <= '0;
            r_slot         <= '0;
            r_frame        <= '0;
            r_build        <= '0;
            r_bflag        <= '0;
            r_header       <= '0;
            r_sub          <= '0;
            r_packet_valid <= 1'b0;
        end else begin
            r_packet_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.packet_request && (w_k != 3'd0)) begin
                        r_k     <= w_k;
                        r_slot  <= '0;
                        r_build <= '0;
                        r_bflag <= '0;
                        r_state <= ASSEMBLE;
                    end
                end
                ASSEMBLE: begin
                    r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;
                    r_slot  <= r_slot + 2'd1;
                    r_build <= w_build_next;
                    r_bflag <= w_bflag_next;
                    if (w_last) begin
                        r_sub          <= w_build_next;
                        r_header       <= {w_bflag_next, 4'b0000, 3'b000, C_LAYOUT, w_present, 8'h02};
                        r_packet_valid <= 1'b1;
                        r_state        <= EMIT;
                    end
                end
                EMIT:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sample_ready = !w_full;
    assign bus.busy         = (r_state != IDLE);
    assign bus.packet_valid = r_packet_valid;
    assign bus.header       = r_header;
    assign bus.sub          = r_sub;
    assign bus.overflow     = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_audio_sample_packetizer.sv
`default_nettype none
// ============================================================================
//  tb_audio_sample_packetizer
//  Scoreboard bench: a 2ch/16-bit and an 8ch/24-bit packetizer instance.
//  Revision: 1.0
// ============================================================================
module tb_audio_sample_packetizer;
    localparam int         A_SW    = 16;
    localparam int         A_DEPTH = 8;
    localparam logic [3:0] A_SF    = 4'b0010;
    localparam logic [3:0] A_WL    = 4'b1011;
    localparam int         B_SW    = 24;
    localparam int         B_DEPTH = 4;
    localparam logic [3:0] B_SF    = 4'b1100;
    localparam logic [3:0] B_WL    = 4'b0010;

    typedef struct {
        logic [23:0]      hdr;
        logic [3:0][55:0] sub;
        int               cyc;
    } pkt_t;

    logic clk_pixel = 1'b0;
    logic reset     = 1'b1;
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;

    always #5 clk_pixel = ~clk_pixel;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    audio_sample_packetizer_if #(.CHANNELS(2), .SAMPLE_WIDTH(A_SW)) bus_a ();
    audio_sample_packetizer_if #(.CHANNELS(8), .SAMPLE_WIDTH(B_SW)) bus_b ();

    audio_sample_packetizer #(
        .CHANNELS(2), .SAMPLE_WIDTH(A_SW), .FIFO_DEPTH(A_DEPTH),
        .SAMPLING_FREQUENCY(A_SF), .WORD_LENGTH(A_WL)
    ) u_a (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .bus      (bus_a.slave)
    );

    audio_sample_packetizer #(
        .CHANNELS(8), .SAMPLE_WIDTH(B_SW), .FIFO_DEPTH(B_DEPTH),
        .SAMPLING_FREQUENCY(B_SF), .WORD_LENGTH(B_WL)
    ) u_b (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .bus      (bus_b.slave)
    );

    logic [31:0]      qa [$];
    logic [191:0]     qb [$];
    pkt_t             sb_a [$];
    pkt_t             sb_b [$];
    int               frame_a = 0;
    int               frame_b = 0;
    int               pkts_a  = 0;
    int               pkts_b  = 0;
    logic [23:0]      last_hdr_a, last_hdr_b;
    logic [3:0][55:0] last_sub_a, last_sub_b;
    pkt_t             mon_a, mon_b;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cs_bit(input int num, input int f, input logic [3:0] sf, input logic [3:0] wl);
        logic [191:0] cs;
        cs        = '0;
        cs[2]     = 1'b1;
        cs[23:20] = 4'(num);
        cs[27:24] = sf;
        cs[35:32] = wl;
        return cs[f];
    endfunction

    function automatic logic [55:0] mk_sub(input logic [23:0] f0, input logic [23:0] f1,
                                           input logic c0, input logic c1);
        logic p0, p1;
        p0 = ^{f0, 1'b0, 1'b0, c0};
        p1 = ^{f1, 1'b0, 1'b0, c1};
        return {p1, c1, 1'b0, 1'b0, p0, c0, 1'b0, 1'b0, f1, f0};
    endfunction

    // Monitors: every packet_valid pops one expected packet.
    always @(negedge clk_pixel) begin
        if (bus_a.packet_valid === 1'b1) begin
            pkts_a++;
            last_hdr_a = bus_a.header;
            last_sub_a = bus_a.sub;
            if (sb_a.size() == 0) check("a_unexpected_packet", 1'b1, 1'b0);
            else begin
                mon_a = sb_a.pop_front();
                check("a_header", bus_a.header, mon_a.hdr);
                check("a_sub", bus_a.sub, mon_a.sub);
                check("a_packet_cycle", cyc, mon_a.cyc);
            end
        end
    end

    always @(negedge clk_pixel) begin
        if (bus_b.packet_valid === 1'b1) begin
            pkts_b++;
            last_hdr_b = bus_b.header;
            last_sub_b = bus_b.sub;
            if (sb_b.size() == 0) check("b_unexpected_packet", 1'b1, 1'b0);
            else begin
                mon_b = sb_b.pop_front();
                check("b_header", bus_b.header, mon_b.hdr);
                check("b_sub", bus_b.sub, mon_b.sub);
                check("b_packet_cycle", cyc, mon_b.cyc);
            end
        end
    end

    task automatic push_a(input logic [31:0] s);
        @(posedge clk_pixel); #1;
        check("a_sample_ready", bus_a.sample_ready, qa.size() < A_DEPTH);
        bus_a.sample_valid = 1'b1;
        bus_a.sample_word  = s;
        if (qa.size() < A_DEPTH) qa.push_back(s);
        @(posedge clk_pixel); #1;
        bus_a.sample_valid = 1'b0;
    endtask

    task automatic push_b(input logic [191:0] s);
        @(posedge clk_pixel); #1;
        check("b_sample_ready", bus_b.sample_ready, qb.size() < B_DEPTH);
        bus_b.sample_valid = 1'b1;
        bus_b.sample_word  = s;
        if (qb.size() < B_DEPTH) qb.push_back(s);
        @(posedge clk_pixel); #1;
        bus_b.sample_valid = 1'b0;
    endtask

    // poke_busy holds the request through the first busy cycle; it must be ignored.
    task automatic req_a(input bit poke_busy);
        int               k;
        logic [31:0]      s;
        logic [3:0]       bflag, present;
        pkt_t             e;
        k       = (qa.size() > 4) ? 4 : qa.size();
        e.sub   = '0;
        bflag   = '0;
        present = '0;
        for (int j = 0; j < k; j++) begin
            s = qa.pop_front();
            e.sub[j] = mk_sub({s[15:0], 8'h00}, {s[31:16], 8'h00},
                              cs_bit(1, frame_a, A_SF, A_WL), cs_bit(2, frame_a, A_SF, A_WL));
            bflag[j]   = (frame_a == 0);
            present[j] = 1'b1;
            frame_a    = (frame_a + 1) % 192;
        end
        e.hdr = {bflag, 4'h0, 4'h0, present, 8'h02};
        @(posedge clk_pixel); #1;
        bus_a.packet_request = 1'b1;
        e.cyc = cyc + k + 1;
        if (k > 0) sb_a.push_back(e);
        @(posedge clk_pixel); #1;
        check("a_busy_after_request", bus_a.busy, k > 0);
        if (!poke_busy) bus_a.packet_request = 1'b0;
        @(posedge clk_pixel); #1;
        bus_a.packet_request = 1'b0;
        repeat (k + 3) @(posedge clk_pixel);
        #1;
    endtask

    task automatic req_b();
        int          k;
        logic [191:0] s;
        pkt_t        e;
        k     = (qb.size() > 0) ? 1 : 0;
        e.sub = '0;
        e.hdr = {4'h0, 4'h0, 8'h1F, 8'h02};
        if (k > 0) begin
            s = qb.pop_front();
            for (int p = 0; p < 4; p++)
                e.sub[p] = mk_sub(s[2*p*24 +: 24], s[(2*p+1)*24 +: 24],
                                  cs_bit(2*p+1, frame_b, B_SF, B_WL), cs_bit(2*p+2, frame_b, B_SF, B_WL));
            e.hdr[20] = (frame_b == 0);
            frame_b   = (frame_b + 1) % 192;
        end
        @(posedge clk_pixel); #1;
        bus_b.packet_request = 1'b1;
        e.cyc = cyc + k + 1;
        if (k > 0) sb_b.push_back(e);
        @(posedge clk_pixel); #1;
        check("b_busy_after_request", bus_b.busy, k > 0);
        bus_b.packet_request = 1'b0;
        repeat (k + 3) @(posedge clk_pixel);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_a_packet_valid", bus_a.packet_valid, 1'b0);
        check("rst_a_busy", bus_a.busy, 1'b0);
        check("rst_a_overflow", bus_a.overflow, 1'b0);
        check("rst_a_header", bus_a.header, 24'h0);
        check("rst_a_sub", bus_a.sub, 224'h0);
        check("rst_a_sample_ready", bus_a.sample_ready, 1'b1);
        check("rst_b_busy", bus_b.busy, 1'b0);
        check("rst_b_sample_ready", bus_b.sample_ready, 1'b1);
    endtask

    logic [191:0] bs0, bs1;

    initial begin
        bus_a.sample_valid = 1'b0; bus_a.sample_word = '0; bus_a.packet_request = 1'b0;
        bus_b.sample_valid = 1'b0; bus_b.sample_word = '0; bus_b.packet_request = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk_pixel);
        #1 reset = 1'b0;
        #1 check_reset_state();

        // 8-channel layout: two single-sample packets, then an empty request.
        for (int c = 0; c < 8; c++) begin
            bs0[c*24 +: 24] = 24'hABC000 + 24'(c * 'h111);
            bs1[c*24 +: 24] = 24'h800001 + 24'(c);
        end
        push_b(bs0);
        push_b(bs1);
        req_b();
        check("b_hdr_first", last_hdr_b, 24'h101F02);
        req_b();
        check("b_hdr_second", last_hdr_b, 24'h001F02);
        check("b_ch7_field", last_sub_b[3][47:24], 24'h800008);
        req_b();
        check("b_packet_count", pkts_b, 2);

        // 2-channel: three samples, first frame, 16-bit alignment and parity.
        push_a({16'h1234, 16'hA5A5});
        push_a({16'h0F0F, 16'h0001});
        push_a({16'hFFFF, 16'h8000});
        req_a(1'b0);
        check("a_hdr_three", last_hdr_a, 24'h100702);
        check("a_sub3_empty", last_sub_a[3], 56'h0);
        check("a_ch0_field", last_sub_a[0][23:0], 24'hA5A500);
        check("a_ch1_field", last_sub_a[0][47:24], 24'h123400);
        check("a_p0", last_sub_a[0][51], 1'b0);
        check("a_p1", last_sub_a[0][55], 1'b1);

        // Overflow: nine pushes into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) push_a({16'(i + 16'h0100), 16'(i * 16'h0111)});
        check("a_ready_when_full", bus_a.sample_ready, 1'b0);
        check("a_overflow_set", bus_a.overflow, 1'b1);
        req_a(1'b1);
        req_a(1'b0);
        check("a_overflow_sticky", bus_a.overflow, 1'b1);
        req_a(1'b0);
        check("a_packet_count", pkts_a, 3);

        @(posedge clk_pixel); #1 reset = 1'b1;
        qa.delete(); qb.delete(); frame_a = 0; frame_b = 0;
        repeat (2) @(posedge clk_pixel);
        #1 reset = 1'b0;
        #1 check_reset_state();

        // Frame counter wrap over 49 packets of four samples.
        for (int i = 0; i < 49; i++) begin
            for (int j = 0; j < 4; j++) push_a({16'(i * 7 + j), 16'(i * 13 + j * 3 + 1)});
            req_a(1'b0);
            if (i == 0) begin
                check("wrap_hb2_first", last_hdr_a[23:16], 8'h10);
                check("cs_bit2_c0", last_sub_a[2][50], 1'b1);
                check("cs_bit2_c1", last_sub_a[2][54], 1'b1);
            end
            if (i == 5) begin
                check("cs_chnum_c0", last_sub_a[0][50], 1'b1);
                check("cs_chnum_c1", last_sub_a[0][54], 1'b0);
            end
            if (i == 6) check("cs_sf_bit25", last_sub_a[1][50], 1'b1);
            if (i == 47) check("wrap_hb2_48th", last_hdr_a[23:16], 8'h00);
            if (i == 48) check("wrap_hb2_49th", last_hdr_a[23:20], 4'b0001);
        end

        // Reset in the middle of ASSEMBLE discards the packet.
        for (int j = 0; j < 4; j++) push_a({16'hCAFE, 16'(j)});
        @(posedge clk_pixel); #1 bus_a.packet_request = 1'b1;
        @(posedge clk_pixel); #1 bus_a.packet_request = 1'b0;
        check("abort_busy_before", bus_a.busy, 1'b1);
        reset = 1'b1;
        #1 check("abort_busy_async", bus_a.busy, 1'b0);
        qa.delete(); frame_a = 0;
        @(posedge clk_pixel); #1 reset = 1'b0;
        repeat (8) @(posedge clk_pixel);
        #1 check("abort_ready", bus_a.sample_ready, 1'b1);
        push_a({16'h5555, 16'h3333});
        req_a(1'b0);
        check("abort_hdr_after", last_hdr_a, 24'h100102);

        repeat (10) @(posedge clk_pixel);
        check("a_missing_packets", sb_a.size(), 0);
        check("b_missing_packets", sb_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
